// File: rtl/md_unit_param.sv
// Multiply/divide unit with HI/LO: mult/madd/msub/div with programmable latency counters.
// Optional MD_ABORT_EN adds an abort port that kills the in-flight op without committing.
module md_unit_param #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
`ifdef MD_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             start,
   input  logic             we,
   input  logic             hilo,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] OP_DIV  = 3'd2;
   localparam logic [2:0] OP_DIVU = 3'd3;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra, rb;
   logic [2:0]       rop;
   logic             kill;

`ifdef MD_ABORT_EN
   assign kill = abort;
`else
   assign kill = 1'b0;
`endif

   assign busy = (cnt != '0);

   // Even opcodes are the signed variants for both multiply and divide.
   logic sgn, neg_a, neg_b;
   assign sgn   = ~rop[0];
   assign neg_a = sgn & ra[WIDTH-1];
   assign neg_b = sgn & rb[WIDTH-1];

   logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, mul_res;
   assign ext_a   = {{WIDTH{neg_a}}, ra};
   assign ext_b   = {{WIDTH{neg_b}}, rb};
   // Low 2*WIDTH bits of the extended product are correct for both signednesses.
   assign prod    = ext_a * ext_b;
   assign acc     = {hi, lo};
   assign mul_res = rop[2] ? (rop[1] ? acc - prod : acc + prod) : prod;

   logic             is_div, div_zero;
   logic [WIDTH-1:0] ua, ub, ub_safe, uq, ur, quo, rem;
   assign is_div   = (rop == OP_DIV) || (rop == OP_DIVU);
   assign div_zero = is_div && (rb == '0);
   assign ua       = neg_a ? -ra : ra;
   assign ub       = neg_b ? -rb : rb;
   // Keeps the divider X-free on b==0; that result is never committed.
   assign ub_safe  = (ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
   assign uq       = ua / ub_safe;
   assign ur       = ua % ub_safe;
   // Most-negative / -1 falls out naturally: the magnitude wraps back to most-negative.
   assign quo      = (neg_a ^ neg_b) ? -uq : uq;
   assign rem      = neg_a ? -ur : ur;

   logic launch_div;
   assign launch_div = (op == OP_DIV) || (op == OP_DIVU);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         ra  <= '0;
         rb  <= '0;
         rop <= '0;
         hi  <= '0;
         lo  <= '0;
      end else if (cnt == '0) begin
         if (start) begin
            // An abort coinciding with start suppresses the launch; we is dropped either way.
            if (!kill) begin
               ra  <= a;
               rb  <= b;
               rop <= op;
               cnt <= launch_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end
         end else if (we) begin
            if (hilo) hi <= a;
            else      lo <= a;
         end
      end else if (kill) begin
         cnt <= '0;
      end else begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1) && !div_zero) begin
            if (is_div) begin
               hi <= rem;
               lo <= quo;
            end else begin
               {hi, lo} <= mul_res;
            end
         end
      end
   end

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: hand-computed HI/LO results, busy lengths and hazard cases.
module tb_md_unit_param;

   logic        clk = 1'b0;
   logic        reset, start, we, hilo;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;
`ifdef MD_ABORT_EN
   logic        abort;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   md_unit_param dut (
      .clk   (clk),
      .reset (reset),
`ifdef MD_ABORT_EN
      .abort (abort),
`endif
      .a     (a),
      .b     (b),
      .op    (op),
      .start (start),
      .we    (we),
      .hilo  (hilo),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Returns at the negedge just after the launch edge (first busy cycle).
   task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy cycles from the current negedge; bounded so a stuck busy cannot hang.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wr(input logic hl, input logic [31:0] val);
      @(negedge clk);
      we = 1'b1; hilo = hl; a = val;
      @(negedge clk);
      we = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b0; start = 1'b0; we = 1'b0; hilo = 1'b0;
      op = 3'd0; a = '0; b = '0;
`ifdef MD_ABORT_EN
      abort = 1'b0;
`endif
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // mult -2 * 3
      launch(3'd0, 32'hFFFF_FFFE, 32'd3);
      chk("mult_hold_lo", lo, 32'h0);
      wait_idle(n);
      chk("mult_cycles", n, 32'd5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);

      // multu 0xFFFFFFFE * 3
      launch(3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      chk("multu_hi", hi, 32'h0000_0002);
      chk("multu_lo", lo, 32'hFFFF_FFFA);

      // div -7 / 2
      launch(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      chk("div_cycles", n, 32'd10);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      // divu 7 / 0 leaves hi/lo alone but still takes full latency
      launch(3'd3, 32'd7, 32'd0);
      wait_idle(n);
      chk("div0_cycles", n, 32'd10);
      chk("div0_lo", lo, 32'hFFFF_FFFD);
      chk("div0_hi", hi, 32'hFFFF_FFFF);

      // most-negative / -1
      launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      chk("divmn_lo", lo, 32'h8000_0000);
      chk("divmn_hi", hi, 32'h0);

      // mtlo / mthi then accumulate
      wr(1'b0, 32'hFFFF_FFFF);
      chk("mtlo", lo, 32'hFFFF_FFFF);
      wr(1'b1, 32'h0);
      chk("mthi", hi, 32'h0);
      launch(3'd5, 32'd1, 32'd1);
      wait_idle(n);
      chk("maddu_hi", hi, 32'd1);
      chk("maddu_lo", lo, 32'd0);
      launch(3'd6, 32'd1, 32'd2);
      wait_idle(n);
      chk("msub_hi", hi, 32'd0);
      chk("msub_lo", lo, 32'hFFFF_FFFE);

      // start at cycles 2 and 4, we at cycle 3 of a running mult 5*5
      launch(3'd0, 32'd5, 32'd5);
      op = 3'd2; a = 32'd7; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0; we = 1'b1; hilo = 1'b1; a = 32'h0000_DEAD;
      @(negedge clk);
      we = 1'b0; start = 1'b1; a = 32'd3; b = 32'd11;
      @(negedge clk);
      start = 1'b0;
      chk("busy_we_hi", hi, 32'd0);
      wait_idle(n);
      chk("busy_ign_cycles", n + 3, 32'd5);
      chk("busy_ign_hi", hi, 32'd0);
      chk("busy_ign_lo", lo, 32'd25);
      @(negedge clk);
      chk("no_relaunch", {31'b0, busy}, 32'd0);

      // start and we together in idle: start wins
      op = 3'd0; a = 32'd2; b = 32'd3; start = 1'b1; we = 1'b1; hilo = 1'b0;
      @(negedge clk);
      start = 1'b0; we = 1'b0;
      chk("st_we_busy", {31'b0, busy}, 32'd1);
      chk("st_we_lo_hold", lo, 32'd25);
      wait_idle(n);
      chk("st_we_lo", lo, 32'd6);

      // asynchronous reset in the middle of a div
      launch(3'd2, 32'd100, 32'd7);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      launch(3'd0, 32'd3, 32'd4);
      wait_idle(n);
      chk("post_rst_cycles", n, 32'd5);
      chk("post_rst_lo", lo, 32'd12);
      chk("post_rst_hi", hi, 32'd0);

`ifdef MD_ABORT_EN
      launch(3'd0, 32'd5, 32'd5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("abort_lo", lo, 32'd12);
      op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("abort_start_lo", lo, 32'd12);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
